osc_hf_div_sequencer: RTL
=========================

// Module: osc_hf_div_sequencer
// PURPOSE
//  Sequences run-time reconfiguration of the LIFCL OSC_CORE high-frequency output.
//  Accepts {divider, enable} requests over a valid/ready handshake. Drives the HF output
//  enable and HF divider select with a glitch-safe sequence: gate, settle, apply, lock wait.
//  Sits between fabric control logic and the OSC_CORE primitive wrapper.
// PARAMETERS
//  DIV_W        8   width of HF divider select
//  DIV_MAX      255 largest legal divider value; larger requests are rejected
//  DIV_RESET    7   hf_div value at reset
//  OFF_CYCLES   4   clocks hf_en is held low before the divider changes (>=1)
//  LOCK_CYCLES  16  clocks waited after re-enable before completion (>=1)
//  CNT_W        8   counter width; must hold max(OFF_CYCLES,LOCK_CYCLES)-1
// PORTS
//  clk        in   1      control clock (independent of the HF output)
//  rst_n      in   1      asynchronous active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      block can accept a request (registered)
//  req_div    in   DIV_W  requested divider select
//  req_en     in   1      requested HF output enable
//  hf_en      out  1      to OSC_CORE HF output enable (registered)
//  hf_div     out  DIV_W  to OSC_CORE HF divider select (registered)
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle completion pulse (registered)
//  err        out  1      qualifies done: request rejected, outputs untouched
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, hf_en=0, hf_div=DIV_RESET, req_ready=1,
//   done=0, err=0, cnt=0. Reset mid-sequence aborts it; the captured request is discarded.
//  Handshake: transfer on a clock edge with req_valid&req_ready. req_ready=1 only in IDLE.
//   req_div and req_en are captured at acceptance; later input changes are ignored.
//   req_valid with req_ready=0 has no effect.
//  States: IDLE, OFF_WAIT, APPLY, ON_WAIT, RESP. Edge 0 is the accepting edge.
//  Priority at acceptance, in order:
//   1) req_div>DIV_MAX: ->RESP with done<=1, err<=1. hf_en and hf_div unchanged.
//   2) req_div==hf_div && req_en==hf_en: ->RESP with done<=1, err<=0 (fast path).
//   3) otherwise: ->OFF_WAIT, hf_en<=0, cnt<=OFF_CYCLES-1, req_ready<=0.
//  OFF_WAIT: cnt decrements each edge. On the edge seen with cnt==0: ->APPLY.
//  APPLY (one cycle): on its exit edge (edge OFF_CYCLES+1), hf_div<=captured div, then:
//   en=1: hf_en<=1, cnt<=LOCK_CYCLES-1, ->ON_WAIT.
//   en=0: ->RESP with done<=1.
//  ON_WAIT: cnt decrements; at cnt==0: ->RESP with done<=1.
//  RESP (one cycle): next edge ->IDLE, done<=0, err<=0, req_ready<=1.
//  Invariant: hf_div changes only on a cycle where hf_en==0 (never while HF output runs).
//  The full path runs even if hf_en is already 0, so settle time is uniform.
//  done timing, counted in edges after edge 0:
//   reject or fast path: done high after edge 0.
//   en=0: done high after edge OFF_CYCLES+1.
//   en=1: done high after edge OFF_CYCLES+LOCK_CYCLES+1.
//  Back-to-back: a new request is accepted at the earliest on the edge after done falls.
// TESTING
//  1) Reset release -> hf_en=0, hf_div=7, req_ready=1, done=0, busy=0.
//  2) Request div=3,en=1 accepted at edge 0 -> hf_en=0 for edges 0..5.
//     hf_div=3 and hf_en=1 after edge 5; done=1 for exactly one cycle after edge 21.
//  3) Repeat identical request div=3,en=1 -> done=1,err=0 after edge 0; hf_en and hf_div
//     never toggle; req_ready=1 again after edge 1.
//  4) DIV_MAX=15, request div=20 -> done=1,err=1 after edge 0; hf_div and hf_en unchanged.
//  5) Request div=9,en=0 from running state -> hf_en=0 at edge 0; hf_div=9 after edge 5;
//     done after edge 5; hf_en stays 0.
//  6) rst_n low during ON_WAIT -> immediate hf_en=0, hf_div=7, state IDLE, no done pulse.
//     Assert throughout: hf_div never changes while hf_en=1.

Source files
------------

// File: rtl/osc_hf_div_sequencer.sv
// Glitch-safe run-time reconfiguration sequencer for the OSC_CORE HF output.
// Each request gates hf_en, waits, applies the new divider, then waits for lock.
module osc_hf_div_sequencer #(
    parameter int DIV_W       = 8,
    parameter int DIV_MAX     = 255,
    parameter int DIV_RESET   = 7,
    parameter int OFF_CYCLES  = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DIV_W-1:0] req_div,
    input  logic             req_en,
    output logic             hf_en,
    output logic [DIV_W-1:0] hf_div,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OFF_WAIT,
        S_APPLY,
        S_ON_WAIT,
        S_RESP
    } state_t;

    localparam logic [DIV_W:0]   LP_DIV_MAX   = (DIV_W+1)'(DIV_MAX);
    localparam logic [DIV_W-1:0] LP_DIV_RESET = DIV_W'(DIV_RESET);
    localparam logic [CNT_W-1:0] LP_OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_cap_div;
    logic             r_cap_en;
    logic             r_hf_en;
    logic [DIV_W-1:0] r_hf_div;
    logic             r_ready;
    logic             r_done;
    logic             r_err;

    logic             w_out_of_range;
    logic             w_no_change;

    assign w_out_of_range = ({1'b0, req_div} > LP_DIV_MAX);
    assign w_no_change    = (req_div == r_hf_div) && (req_en == r_hf_en);

    // NOTE: all state here updates with non-blocking assignments so every
    // register samples pre-edge values; blocking would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cap_div <= LP_DIV_RESET;
            r_cap_en  <= 1'b0;
            r_hf_en   <= 1'b0;
            r_hf_div  <= LP_DIV_RESET;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_cap_div <= req_div;
                        r_cap_en  <= req_en;
                        r_ready   <= 1'b0;
                        if (w_out_of_range) begin
                            r_state <= S_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_no_change) begin
                            r_state <= S_RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= S_OFF_WAIT;
                            r_hf_en <= 1'b0;
                            r_cnt   <= LP_OFF_LOAD;
                        end
                    end
                end

                S_OFF_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_APPLY;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                // hf_en has been low for the whole settle window, so the divider may move now.
                S_APPLY: begin
                    r_hf_div <= r_cap_div;
                    if (r_cap_en) begin
                        r_hf_en <= 1'b1;
                        r_cnt   <= LP_LOCK_LOAD;
                        r_state <= S_ON_WAIT;
                    end else begin
                        r_state <= S_RESP;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end

                S_ON_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RESP;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_ready;
    assign hf_en     = r_hf_en;
    assign hf_div    = r_hf_div;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);

endmodule
